// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM states, parameter defaults and lowest-set-bit priority encoder for irq_pend_ctl
package irq_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_SVC = 2'd2} state_t;
  localparam int NSRC_DEF = 5;
  localparam int VW_DEF = 3;
  function automatic int prio_enc(input logic [31:0] v);
    prio_enc = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) prio_enc = i;
  endfunction
endpackage

// File: rtl/irq_sync_bit.sv
// irq_sync_bit: ld-gated synchroniser chain + history flop for one source (sys_clk, reset, i_src, i_ld -> o_last, o_rise; IRQ_PEND_LEVEL_EN drops history)
module irq_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic i_src,
  input  logic i_ld,
  output logic o_last,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  always_ff @(posedge sys_clk)
    if (reset) r_sync <= '0;
    else if (i_ld) r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
  assign o_last = r_sync[SYNC_STAGES-1];
`ifdef IRQ_PEND_LEVEL_EN
  assign o_rise = 1'b0;
`else
  logic r_hist;
  always_ff @(posedge sys_clk)
    if (reset) r_hist <= 1'b0;
    else if (i_ld) r_hist <= o_last;
  assign o_rise = o_last & ~r_hist & i_ld;
`endif
endmodule

// File: rtl/irq_pend_ctl.sv
// irq_pend_ctl: sync/edge-latch/mask/prioritise interrupts into a req/ack/rti handshake (in: sys_clk reset src ld mask_wr mask_din clr_wr clr_din ack rti; out: mask_q pend irq_req irq_vec in_svc; IRQ_PEND_LEVEL_EN = level-sensitive pend)
module irq_pend_ctl
  import irq_pkg::*;
#(
  parameter int NSRC        = NSRC_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int VW          = VW_DEF
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            ld,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_din,
  input  logic            clr_wr,
  input  logic [NSRC-1:0] clr_din,
  input  logic            ack,
  input  logic            rti,
  output logic [NSRC-1:0] mask_q,
  output logic [NSRC-1:0] pend,
  output logic            irq_req,
  output logic [VW-1:0]   irq_vec,
  output logic            in_svc
);
  state_t          r_state, w_nxt;
  logic [NSRC-1:0] r_mask, w_last, w_rise, w_act, w_oh;
  logic [VW-1:0]   r_vec, w_win;
  logic            w_sel;
  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .sys_clk(sys_clk),
      .reset(reset),
      .i_src(src[g]),
      .i_ld(ld),
      .o_last(w_last[g]),
      .o_rise(w_rise[g])
    );
  end
`ifdef IRQ_PEND_LEVEL_EN
  logic w_unused;
  assign w_unused = ^{clr_wr, clr_din, w_rise};
  assign pend = w_last;
`else
  logic [NSRC-1:0] r_pend, w_clr;
  assign w_clr = (clr_wr ? clr_din : '0) | ((r_state == ST_REQ && ack) ? w_oh : '0);
  always_ff @(posedge sys_clk)
    if (reset) r_pend <= '0;
    else r_pend <= (r_pend & ~w_clr) | w_rise;
  assign pend = r_pend;
`endif
  assign w_act = pend & r_mask;
  assign w_win = VW'(prio_enc(32'(w_act)));
  assign w_oh  = NSRC'(1) << r_vec;
  assign w_sel = |(w_act & w_oh);
  always_comb begin
    w_nxt = r_state;
    if (r_state == ST_IDLE && |w_act) w_nxt = ST_REQ;
    if (r_state == ST_REQ) w_nxt = ack ? ST_SVC : (w_sel ? ST_REQ : ST_IDLE);
    if (r_state == ST_SVC && rti) w_nxt = ST_IDLE;
  end
  always_ff @(posedge sys_clk)
    if (reset) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_nxt;
      if (mask_wr) r_mask <= mask_din;
      if (r_state == ST_IDLE && |w_act) r_vec <= w_win;
    end
  assign mask_q  = r_mask;
  assign irq_vec = r_vec;
  assign irq_req = r_state == ST_REQ;
  assign in_svc  = r_state == ST_SVC;
endmodule

// File: tb/tb_irq_pend_ctl.sv
// tb_irq_pend_ctl: directed self-checking bench for irq_pend_ctl
module tb_irq_pend_ctl;
  logic       sys_clk = 1'b0, reset = 1'b1, ld = 1'b1, mask_wr = 1'b0, clr_wr = 1'b0, ack = 1'b0, rti = 1'b0;
  logic [4:0] src = '0, mask_din = '0, clr_din = '0;
  logic [4:0] mask_q, pend;
  logic [2:0] irq_vec;
  logic       irq_req, in_svc;
  int         errs = 0, n = 0;
  always #5 sys_clk = ~sys_clk;
  irq_pend_ctl dut (
    .sys_clk(sys_clk), .reset(reset), .src(src), .ld(ld),
    .mask_wr(mask_wr), .mask_din(mask_din), .clr_wr(clr_wr), .clr_din(clr_din),
    .ack(ack), .rti(rti), .mask_q(mask_q), .pend(pend),
    .irq_req(irq_req), .irq_vec(irq_vec), .in_svc(in_svc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask
  task automatic set_mask(input logic [4:0] m);
    mask_wr = 1'b1; mask_din = m; tick(); mask_wr = 1'b0;
  endtask
  task automatic ack_rti();
    ack = 1'b1; tick(); ack = 1'b0;
    rti = 1'b1; tick(); rti = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_pend"}, 32'(pend), 0);
    chk({tag, "_mask"}, 32'(mask_q), 0);
    chk({tag, "_req"}, 32'(irq_req), 0);
    chk({tag, "_vec"}, 32'(irq_vec), 0);
    chk({tag, "_svc"}, 32'(in_svc), 0);
  endtask
  initial begin
    tick(2);
    reset = 1'b0;
    chk_zero("rst");
    set_mask(5'b11111);
    chk("mask_wr", 32'(mask_q), 'h1f);
`ifdef IRQ_PEND_LEVEL_EN
    src = 5'b00001;
    tick(2);
    chk("lvl_pend", 32'(pend), 'h01);
    tick();
    chk("lvl_req", 32'(irq_req), 1);
    chk("lvl_vec", 32'(irq_vec), 0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("lvl_svc", 32'(in_svc), 1);
    chk("lvl_pend_kept", 32'(pend), 'h01);
    rti = 1'b1; tick(); rti = 1'b0;
    chk("lvl_idle", 32'(irq_req), 0);
    tick();
    chk("lvl_rereq", 32'(irq_req), 1);
    src = '0;
    tick(2);
    chk("lvl_drop", 32'(pend), 0);
    tick();
    chk("lvl_withdraw", 32'(irq_req), 0);
`else
    src = 5'b00100;
    tick(2);
    chk("t1_pend_e1", 32'(pend), 0);
    tick();
    chk("t1_pend_e2", 32'(pend), 'h04);
    chk("t1_req_e2", 32'(irq_req), 0);
    tick();
    chk("t1_req", 32'(irq_req), 1);
    chk("t1_vec", 32'(irq_vec), 2);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_svc", 32'(in_svc), 1);
    chk("t1_pend_clr", 32'(pend), 0);
    chk("t1_req_svc", 32'(irq_req), 0);
    rti = 1'b1; tick(); rti = 1'b0;
    chk("t1_idle_svc", 32'(in_svc), 0);
    chk("t1_idle_req", 32'(irq_req), 0);
    src = 5'b01010;
    tick(3);
    chk("t2_pend", 32'(pend), 'h0a);
    tick();
    chk("t2_vec1", 32'(irq_vec), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_pend3", 32'(pend), 'h08);
    chk("t2_svc", 32'(in_svc), 1);
    rti = 1'b1; tick(); rti = 1'b0;
    chk("t2_idle", 32'(irq_req), 0);
    tick();
    chk("t2_req3", 32'(irq_req), 1);
    chk("t2_vec3", 32'(irq_vec), 3);
    ack_rti();
    src = '0;
    tick(3);
    ld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      src = {4'b0, i[0]};
      tick();
    end
    chk("t3_ld0_pend", 32'(pend), 0);
    chk("t3_ld0_req", 32'(irq_req), 0);
    src = 5'b00001; ld = 1'b1;
    tick(2);
    chk("t3_pend_e1", 32'(pend), 0);
    tick();
    chk("t3_pend_e2", 32'(pend), 'h01);
    tick();
    chk("t3_vec0", 32'(irq_vec), 0);
    chk("t3_req", 32'(irq_req), 1);
    ack_rti();
    src = 5'b10000;
    tick(4);
    chk("t4_req", 32'(irq_req), 1);
    chk("t4_vec4", 32'(irq_vec), 4);
    set_mask(5'b01111);
    tick();
    chk("t4_withdraw", 32'(irq_req), 0);
    chk("t4_pend_kept", 32'(pend), 'h10);
    chk("t4_svc", 32'(in_svc), 0);
    set_mask(5'b11111);
    tick();
    chk("t4_rereq", 32'(irq_req), 1);
    chk("t4_revec", 32'(irq_vec), 4);
    ack_rti();
    src = 5'b00010;
    tick(3);
    src = 5'b00010;
    src = '0;
    tick(3);
    src = 5'b00010;
    tick(2);
    clr_wr = 1'b1; clr_din = 5'b00010;
    tick();
    clr_wr = 1'b0;
    chk("t5_set_wins", 32'(pend), 'h02);
    clr_wr = 1'b1;
    tick();
    clr_wr = 1'b0;
    chk("t5_clr", 32'(pend), 0);
    chk("t5_clr_req", 32'(irq_req), 1);
    tick();
    chk("t5_clr_withdraw", 32'(irq_req), 0);
    src = '0;
    tick(3);
    src = 5'b00010;
    tick(4);
    chk("t5_req", 32'(irq_req), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t5_svc", 32'(in_svc), 1);
    src = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk_zero("t5_rst");
`endif
    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
